// File: rtl/noc_reader_vc_sched.sv
// Output-side VC scheduler for the fabric-port reader.
// Picks a non-empty VC round-robin and drains it packet-atomically into the
// async FIFO write port. Each popped flit returns one credit to the NoC.
// Optional build macro: NOC_READER_SCHED_INTERLEAVE_EN selects flit-level
// round-robin with no packet lock, and o_busy tied low.
module noc_reader_vc_sched #(
    parameter int WIDTH  = 8,
    parameter int NUM_VC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VC-1:0]         i_vc_nonempty,
    input  logic [NUM_VC*WIDTH-1:0]   i_vc_flit,
    output logic [NUM_VC-1:0]         o_vc_pop,
    output logic [WIDTH-1:0]          o_data_out,
    output logic                      o_write_en,
    input  logic                      o_ready_in,
    output logic [NUM_VC-1:0]         o_credits_out,
    output logic                      o_busy
);

    localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                      state_q, state_d;
    logic [VC_ADDRESS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [VC_ADDRESS_WIDTH-1:0] lock_vc_q, lock_vc_d;
    logic [WIDTH-1:0]            data_q, data_d;
    logic                        write_en_q, write_en_d;
    logic [NUM_VC-1:0]           credits_q, credits_d;

    logic [VC_ADDRESS_WIDTH-1:0] cand_vc;
    logic [VC_ADDRESS_WIDTH-1:0] sel_vc;
    logic                        sel_found;
    logic [VC_ADDRESS_WIDTH-1:0] grant_vc;
    logic                        pop_en;
    logic [WIDTH-1:0]            grant_flit;
    logic [NUM_VC-1:0]           pop_onehot;
    logic                        grant_tail;

    function automatic logic [VC_ADDRESS_WIDTH-1:0] next_vc(
        input logic [VC_ADDRESS_WIDTH-1:0] v
    );
        return VC_ADDRESS_WIDTH'((int'(v) + 1) % NUM_VC);
    endfunction

    // Round-robin search: first non-empty VC at or above rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        cand_vc   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand_vc = VC_ADDRESS_WIDTH'((int'(rr_ptr_q) + i) % NUM_VC);
            if (!sel_found && i_vc_nonempty[cand_vc]) begin
                sel_found = 1'b1;
                sel_vc    = cand_vc;
            end
        end
    end

    // Grant decision: locked VC owns the port mid-packet, otherwise the
    // round-robin winner. Nothing pops while in reset or when FIFO is not ready.
    always_comb begin
        grant_vc = (state_q == StLocked) ? lock_vc_q : sel_vc;
        if (state_q == StLocked) begin
            pop_en = o_ready_in && !rst && i_vc_nonempty[lock_vc_q];
        end else begin
            pop_en = o_ready_in && !rst && sel_found;
        end
        grant_flit = '0;
        pop_onehot = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (grant_vc == VC_ADDRESS_WIDTH'(v)) begin
                grant_flit    = i_vc_flit[v*WIDTH +: WIDTH];
                pop_onehot[v] = pop_en;
            end
        end
        grant_tail = grant_flit[WIDTH-3];
    end

    // Next-state: lock/unlock at packet boundaries, register the output flit.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = lock_vc_q;
        data_d     = data_q;
        write_en_d = pop_en;
        credits_d  = pop_onehot;
        if (pop_en) begin
            data_d = grant_flit;
`ifdef NOC_READER_SCHED_INTERLEAVE_EN
            rr_ptr_d = next_vc(grant_vc);
`else
            unique case (state_q)
                StIdle: begin
                    if (grant_tail) begin
                        rr_ptr_d = next_vc(grant_vc);
                    end else begin
                        state_d   = StLocked;
                        lock_vc_d = grant_vc;
                    end
                end
                StLocked: begin
                    if (grant_tail) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_vc(lock_vc_q);
                    end
                end
                default: state_d = StIdle;
            endcase
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_vc_q  <= '0;
            data_q     <= '0;
            write_en_q <= 1'b0;
            credits_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_vc_q  <= lock_vc_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
            credits_q  <= credits_d;
        end
    end

    assign o_vc_pop      = pop_onehot;
    assign o_data_out    = data_q;
    assign o_write_en    = write_en_q;
    assign o_credits_out = credits_q;
`ifdef NOC_READER_SCHED_INTERLEAVE_EN
    assign o_busy = 1'b0;
`else
    assign o_busy = (state_q == StLocked);
`endif

endmodule

// File: tb/tb_noc_reader_vc_sched.sv
// Directed bench for noc_reader_vc_sched (packet-atomic default build).
// Upstream VC buffers are modelled as queues popped on o_vc_pop.
module tb_noc_reader_vc_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_vc_nonempty;
    logic [15:0] i_vc_flit;
    logic [1:0]  o_vc_pop;
    logic [7:0]  o_data_out;
    logic        o_write_en;
    logic        o_ready_in;
    logic [1:0]  o_credits_out;
    logic        o_busy;

    int tests = 0;
    int fails = 0;
    int cred_cnt = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] pop_seen;

    noc_reader_vc_sched #(.WIDTH(8), .NUM_VC(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_vc_nonempty (i_vc_nonempty),
        .i_vc_flit     (i_vc_flit),
        .o_vc_pop      (o_vc_pop),
        .o_data_out    (o_data_out),
        .o_write_en    (o_write_en),
        .o_ready_in    (o_ready_in),
        .o_credits_out (o_credits_out),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        i_vc_nonempty[0] = (q0.size() > 0);
        i_vc_nonempty[1] = (q1.size() > 0);
        i_vc_flit[7:0]   = (q0.size() > 0) ? q0[0] : 8'h00;
        i_vc_flit[15:8]  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // One clock: sample the pop mid-cycle, clock it, then retire popped flits.
    task automatic tick();
        drive();
        @(negedge clk);
        pop_seen = o_vc_pop;
        @(posedge clk);
        #1;
        if (pop_seen[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop_seen[1] && q1.size() > 0) void'(q1.pop_front());
        cred_cnt += int'(o_credits_out[0]) + int'(o_credits_out[1]);
        drive();
    endtask

    task automatic cyc(input string tag, input logic [1:0] pop, input logic we,
                       input logic [7:0] data, input logic [1:0] cred, input logic busy);
        tick();
        chk({tag, "_pop"}, 32'(pop_seen), 32'(pop));
        chk({tag, "_we"}, 32'(o_write_en), 32'(we));
        if (we) chk({tag, "_data"}, 32'(o_data_out), 32'(data));
        chk({tag, "_cred"}, 32'(o_credits_out), 32'(cred));
        chk({tag, "_busy"}, 32'(o_busy), 32'(busy));
    endtask

    initial begin
        rst = 1'b1;
        o_ready_in = 1'b1;
        q0 = '{8'hC2};
        q1 = '{8'hD3};
        drive();

        // Reset held two cycles with VCs non-empty: no pops, outputs zero.
        cyc("rst0", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("rst0_data", 32'(o_data_out), 32'h0);
        cyc("rst1", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("rst1_data", 32'(o_data_out), 32'h0);
        rst = 1'b0;
        q0.delete();
        q1.delete();

        // Single VC, 4-flit packet on VC1.
        q1 = '{8'hD1, 8'h91, 8'h91, 8'hB1};
        cyc("sv1", 2'b10, 1'b1, 8'hD1, 2'b10, 1'b1);
        cyc("sv2", 2'b10, 1'b1, 8'h91, 2'b10, 1'b1);
        cyc("sv3", 2'b10, 1'b1, 8'h91, 2'b10, 1'b1);
        cyc("sv4", 2'b10, 1'b1, 8'hB1, 2'b10, 1'b0);
        cyc("sv5", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

        // Packet atomicity: both VCs loaded, ready rises.
        o_ready_in = 1'b0;
        q0 = '{8'hC2, 8'h82, 8'h82, 8'hA2};
        q1 = '{8'hD3, 8'h93, 8'h93, 8'hB3};
        cyc("at0", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
        o_ready_in = 1'b1;
        cyc("at1", 2'b01, 1'b1, 8'hC2, 2'b01, 1'b1);
        cyc("at2", 2'b01, 1'b1, 8'h82, 2'b01, 1'b1);
        cyc("at3", 2'b01, 1'b1, 8'h82, 2'b01, 1'b1);
        cyc("at4", 2'b01, 1'b1, 8'hA2, 2'b01, 1'b0);
        cyc("at5", 2'b10, 1'b1, 8'hD3, 2'b10, 1'b1);
        cyc("at6", 2'b10, 1'b1, 8'h93, 2'b10, 1'b1);
        cyc("at7", 2'b10, 1'b1, 8'h93, 2'b10, 1'b1);
        cyc("at8", 2'b10, 1'b1, 8'hB3, 2'b10, 1'b0);
        cyc("at9", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

        // Stall mid-packet on VC0 (rr_ptr is 0 after VC1 tail).
        cred_cnt = 0;
        q0 = '{8'hC6, 8'h86, 8'h86, 8'h86, 8'hA6};
        cyc("st1", 2'b01, 1'b1, 8'hC6, 2'b01, 1'b1);
        cyc("st2", 2'b01, 1'b1, 8'h86, 2'b01, 1'b1);
        cyc("st3", 2'b01, 1'b1, 8'h86, 2'b01, 1'b1);
        o_ready_in = 1'b0;
        chk("st_trail_we", 32'(o_write_en), 32'h1);
        cyc("st4", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
        cyc("st5", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
        cyc("st6", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
        o_ready_in = 1'b1;
        cyc("st7", 2'b01, 1'b1, 8'h86, 2'b01, 1'b1);
        cyc("st8", 2'b01, 1'b1, 8'hA6, 2'b01, 1'b0);
        cyc("st9", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("st_credits", 32'(cred_cnt), 32'd5);
        chk("st_q0_left", 32'(q0.size()), 32'd0);

        // Locked VC1 runs empty while VC0 waits (rr_ptr is 1 after VC0 tail).
        q1 = '{8'hD4};
        q0 = '{8'hC7, 8'hA7};
        cyc("lk1", 2'b10, 1'b1, 8'hD4, 2'b10, 1'b1);
        cyc("lk2", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
        cyc("lk3", 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
        q1.push_back(8'hB4);
        cyc("lk4", 2'b10, 1'b1, 8'hB4, 2'b10, 1'b0);
        cyc("lk5", 2'b01, 1'b1, 8'hC7, 2'b01, 1'b1);
        cyc("lk6", 2'b01, 1'b1, 8'hA7, 2'b01, 1'b0);

        // Reset while locked on VC1 (rr_ptr is 1 after VC0 tail).
        q1 = '{8'hD8, 8'h98, 8'h98, 8'hB8};
        cyc("mr1", 2'b10, 1'b1, 8'hD8, 2'b10, 1'b1);
        rst = 1'b1;
        cyc("mr2", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
        chk("mr2_data", 32'(o_data_out), 32'h0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        // rr_ptr back at 0: single-flit packets, VC0 wins first.
        q0 = '{8'hE0};
        q1 = '{8'hF1};
        cyc("mr3", 2'b01, 1'b1, 8'hE0, 2'b01, 1'b0);
        cyc("mr4", 2'b10, 1'b1, 8'hF1, 2'b10, 1'b0);
        cyc("mr5", 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
